// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO used between pipeline stages on the same clock, for
// example between the DCT output and the quantiser/entropy coder. It is the
// responder on the write handshake and the source on the read handshake.
// Storage is an inferred simple dual-port RAM. The read port is registered,
// so there is one cycle of read latency.
//
// Parameters
//   DATA_WIDTH : word width (default 10)
//   DEPTH      : number of entries; must be a power of two and >= 2 (default 8)
//
// Ports
//   clk        : clock; all logic runs on the rising edge
//   rst        : synchronous, active-high reset
//   wr_en      : write request
//   wr_data    : write data
//   wr_full    : FIFO full; a write is refused while high
//   rd_en      : read request
//   rd_data    : registered read data; holds its value between accepted reads
//   rd_empty   : FIFO empty; a read is refused while high
//   count      : occupancy, 0..DEPTH
//   overflow   : one-cycle pulse after a write attempted while full
//   underflow  : one-cycle pulse after a read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_full,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    // Address width and pointer width. The extra pointer MSB is a wrap bit
    // that tells "full" apart from "empty" when the addresses coincide.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr_accept;
    logic rd_accept;

    // Flags and occupancy depend only on the registered pointers. There is no
    // combinational path from wr_en/rd_en to any status output.
    assign wr_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign rd_empty = (wptr == rptr);
    assign count    = wptr - rptr;  // modulo 2^PW by construction

    // Acceptance uses the flags as they stand before this edge. A write while
    // full is therefore dropped even if a read frees a slot in the same cycle,
    // and a read while empty is refused even if a write lands. There is no
    // bypass from wr_data to rd_data.
    assign wr_accept = wr_en && !wr_full;
    assign rd_accept = rd_en && !rd_empty;

    // Pointers, error pulses and the read register. Reset takes priority over
    // any request in the same cycle, so that cycle's requests are ignored.
    // NOTE: sequential state uses non-blocking assignments. Every register then
    //       samples the values from before the edge, which keeps simulation and
    //       synthesis in agreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && wr_full;
            underflow <= rd_en && rd_empty;

            if (wr_accept) begin
                wptr <= wptr + PW'(1);
            end

            if (rd_accept) begin
                rd_data <= mem[rptr[AW-1:0]];
                rptr    <= rptr + PW'(1);
            end
        end
    end

    // RAM write port. Writes are suppressed during reset, so requests in the
    // reset cycle leave no trace.
    // NOTE: the storage array is deliberately left out of reset. Resetting it
    //       would block RAM inference, and a word is never readable before it
    //       has been written because rd_empty guards every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Directed, self-checking bench for sync_fifo (DATA_WIDTH=10, DEPTH=8).
// A queue scoreboard is the reference. Each stimulus cycle decides acceptance
// from the reference occupancy before the edge. An accepted write pushes its
// word, and an accepted read pops the word that rd_data must show after the
// edge. Every output is compared #1 after each rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic           wr_en;
    logic [DW-1:0]  wr_data;
    logic           wr_full;
    logic           rd_en;
    logic [DW-1:0]  rd_data;
    logic           rd_empty;
    logic [CW-1:0]  count;
    logic           overflow;
    logic           underflow;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_empty  (rd_empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference state.
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_rd_data;
    logic          exp_ovf;
    logic          exp_udf;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one clock cycle with the given inputs, updates the reference, then
    // compares every DUT output against it.
    task automatic cycle(input logic we, input logic [DW-1:0] wd,
                         input logic re, input logic r, input string tag);
        logic m_full;
        logic m_empty;
        m_full  = (sb.size() == DEPTH);
        m_empty = (sb.size() == 0);

        rst     = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;

        if (r) begin
            sb.delete();
            exp_rd_data = '0;
            exp_ovf     = 1'b0;
            exp_udf     = 1'b0;
        end else begin
            exp_ovf = we && m_full;
            exp_udf = re && m_empty;
            if (re && !m_empty) exp_rd_data = sb.pop_front();
            if (we && !m_full)  sb.push_back(wd);
        end

        check({tag, ".count"},     32'(count),     32'(sb.size()));
        check({tag, ".rd_empty"},  32'(rd_empty),  32'(sb.size() == 0));
        check({tag, ".wr_full"},   32'(wr_full),   32'(sb.size() == DEPTH));
        check({tag, ".rd_data"},   32'(rd_data),   32'(exp_rd_data));
        check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));

        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_rd_data = '0;
        exp_ovf     = 1'b0;
        exp_udf     = 1'b0;
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        rd_en       = 1'b0;

        // Reset, then idle for three cycles.
        cycle(1'b0, '0, 1'b0, 1'b1, "reset");
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, "idle");

        // Fill with 0x001..0x008, attempt a 9th write, then drain in order.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, "fill");
        cycle(1'b1, 10'h3FF, 1'b0, 1'b0, "write_full");
        cycle(1'b0, '0, 1'b0, 1'b0, "ovf_clear");
        for (int i = 1; i <= DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");

        // Read while empty with a simultaneous write, then read the word back.
        cycle(1'b1, 10'h155, 1'b1, 1'b0, "rd_empty_wr");
        cycle(1'b0, '0, 1'b0, 1'b0, "after_udf");
        cycle(1'b0, '0, 1'b1, 1'b0, "read_155");

        // Hold occupancy at 4 with simultaneous read/write for 20 cycles.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(10'h040 + i), 1'b0, 1'b0, "prefill4");
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(10'h100 + 7 * i), 1'b1, 1'b0, "stream");
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, "stream_drain");

        // Full FIFO, write and read together: the read wins and the write drops.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(10'h200 + i), 1'b0, 1'b0, "refill");
        cycle(1'b1, 10'h0AB, 1'b1, 1'b0, "full_rw");
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, "full_rw_drain");

        // Reset mid-stream with wr_en held high, then check for stale data.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(10'h300 + i), 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 10'h123, 1'b0, 1'b1, "mid_rst");
        cycle(1'b0, '0, 1'b1, 1'b0, "post_rst_read");
        cycle(1'b1, 10'h2AA, 1'b0, 1'b0, "write_2aa");
        cycle(1'b0, '0, 1'b1, 1'b0, "read_2aa");

        // Random mix of requests, checked against the same scoreboard.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                  1'b0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO that terminates both FIFO handshakes. It is the responder on the write side (`fifoWr_if.syncRx`) and the source on the read side (`fifoRd_if.syncTx`). It buffers 10-bit DCT/code words between pipeline stages that run on the same clock, e.g. between the DCT output and the quantiser/entropy coder. Reads are registered (one-cycle read latency), and storage is an inferred simple dual-port RAM.

## Interface
- `DATA_WIDTH`, default 10: word width; matches the `fifoWr_if`/`fifoRd_if` parameter.
- `DEPTH`, default 8: number of entries; must be a power of two and ≥ 2.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `wr.en` input 1: write request (`fifoWr_if.syncRx`).
- `wr.data` input DATA_WIDTH: write data.
- `wr.full` output 1: FIFO full; a write is not accepted while high.
- `rd.en` input 1: read request (`fifoRd_if.syncTx`).
- `rd.data` output DATA_WIDTH: read data, registered.
- `rd.empty` output 1: FIFO empty; a read is not accepted while high.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: one-cycle pulse when `wr.en` is high while `wr.full` is high.
- `underflow` output 1: one-cycle pulse when `rd.en` is high while `rd.empty` is high.

## Operation
- Pointers:
  - `wptr` and `rptr` are $clog2(DEPTH)+1 bits wide: the MSB is the wrap bit, the LSBs form the RAM address.
  - `count` = `wptr` − `rptr`, taken modulo 2^($clog2(DEPTH)+1).
- Write acceptance: a write is accepted when `wr.en` && !`wr.full`.
  - On acceptance: mem[`wptr`[LSBs]] <= `wr.data`, and `wptr` increments.
- Read acceptance: a read is accepted when `rd.en` && !`rd.empty`.
  - On acceptance: `rd.data` <= mem[`rptr`[LSBs]], and `rptr` increments.
- `rd.data` holds its last value when no read is accepted, including while empty.
- Flags:
  - `wr.full` = (address bits equal) && (wrap bits differ).
  - `rd.empty` = (`wptr` == `rptr`).
  - Both flags, and `count`, are derived from the registered pointers.
- Simultaneous accepted read and write: both pointers advance and `count` is unchanged.
- Write-when-full is rejected even if a read is accepted in the same cycle. The write is dropped and `overflow` pulses, because `full` is evaluated before the read takes effect.
- Read-when-empty is rejected even if a write is accepted in the same cycle. `underflow` pulses and `rd.data` is unchanged. No bypass path from `wr.data` to `rd.data`.
- Pointer wrap-around: the LSBs roll over from DEPTH−1 to 0 and the wrap bit toggles. There is no special case at the wrap.
- Rejected operations never modify memory, pointers, or `rd.data`.
- Memory contents are not reset and are never observable before being written.

## Timing
- Reset values (on the first rising edge with `rst` high):
  - `wptr`, `rptr`, `count` = 0.
  - `rd.empty` = 1, `wr.full` = 0.
  - `rd.data` = 0.
  - `overflow` = `underflow` = 0.
- `rst` has priority over `wr.en`/`rd.en` in the same cycle; requests in that cycle are ignored.
- Reset mid-operation: all stored words are discarded. `rd.empty` is 1 in the cycle after the reset edge, and no stale word is readable afterward.
- Write → empty: a write accepted at edge N makes `rd.empty` fall after edge N (visible in cycle N+1).
- Read latency: a read accepted at edge N presents its word on `rd.data` after edge N, valid through cycle N+1 until the next accepted read.
- Write-to-read minimum: write at edge N, `rd.en` sampled at edge N+1, data valid in cycle N+2.
- `wr.full`, `rd.empty` and `count` update one edge after the causing operation. All three are pure functions of registers (no combinational path from `wr.en`/`rd.en`).
- `overflow`/`underflow` are registered and asserted for exactly the cycle after the offending edge.
- Sustained throughput: one write and one read per cycle indefinitely, provided occupancy stays within 1..DEPTH−1.

## Test plan
- Reset, then idle 3 cycles → `rd.empty`=1, `wr.full`=0, `count`=0, `rd.data`=0, no error pulses.
- Write 0x001..0x008 on consecutive cycles (DEPTH=8):
  - → `count` steps 1..8 and `wr.full`=1 after the 8th edge.
  - A 9th write (0x3FF) → `overflow` pulses once, `count` stays 8.
  - Read back → 0x001..0x008 in order, each one cycle after its read edge, then `rd.empty`=1.
- Read while empty with a simultaneous write of 0x155 → `underflow` pulses and `rd.data` is unchanged. Next cycle `rd.empty`=0 and `count`=1; a read then returns 0x155.
- Keep the FIFO at 4 entries with simultaneous read/write every cycle for 20 cycles (pointers wrap twice) → `count` constant at 4 and output order equal to input order.
- Fill to full, then assert `wr.en` and `rd.en` together → the read is accepted and the write is dropped, `overflow` pulses and `count`=7.
- Fill with 5 words, pulse `rst` for one cycle mid-stream while `wr.en`=1 → after reset `count`=0, `rd.empty`=1 and `rd.data`=0. A subsequent write of 0x2AA then read returns 0x2AA, with no stale data.
